// File: rtl/tt_um_lab2_req_capture.sv
// tt_um_lab2_req_capture: captures request edges as sticky pending flags and serves them highest index first
//   clk, rst_n (async, active-low), ena (ignored)
//   ui_in  = {global enable, req[14:8]}, uio_in = req[7:0]
//   uo_out = served index 0x00-0x0E, or 0xF0 when idle/gap; uio_out, uio_oe = 0
//   LAB2_REQ_SYNC_EN defined: two-flop input synchroniser, otherwise a single register stage
module tt_um_lab2_req_capture #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [1:0] {IDLE, SERVE, GAP} state_t;
  state_t r_state, w_next;
  logic [15:0] r_s1, w_in_s;
  logic [14:0] r_req_d, r_pending, w_edge, w_clr, w_pending;
  logic [3:0] r_idx, w_idx, w_hi;
  logic [7:0] r_cnt, w_cnt, r_uo;
  logic w_unused;
  assign w_unused = ena;
  assign uio_out = 8'h00;
  assign uio_oe = 8'h00;
  assign uo_out = r_uo;
`ifdef LAB2_REQ_SYNC_EN
  logic [15:0] r_s2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= {ui_in, uio_in};
      r_s2 <= r_s1;
    end
  assign w_in_s = r_s2;
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_s1 <= '0;
    else r_s1 <= {ui_in, uio_in};
  assign w_in_s = r_s1;
`endif
  assign w_edge = w_in_s[14:0] & ~r_req_d & {15{w_in_s[15]}};
  assign w_clr = (r_state == SERVE && r_cnt == 8'd0) ? 15'd1 << r_idx : 15'd0;
  // set wins over clear because the edge is OR-ed in after masking
  assign w_pending = w_in_s[15] ? (r_pending & ~w_clr) | w_edge : 15'd0;
  always_comb begin
    w_hi = 4'd0;
    for (int i = 0; i < 15; i++) if (r_pending[i]) w_hi = 4'(i);
  end
  always_comb begin
    w_next = r_state;
    w_idx = r_idx;
    w_cnt = r_cnt;
    case (r_state)
      IDLE: if (|r_pending) begin
        w_next = SERVE;
        w_idx = w_hi;
        w_cnt = 8'(HOLD_CYCLES - 1);
      end
      SERVE: if (r_cnt == 8'd0) w_next = GAP;
             else w_cnt = r_cnt - 8'd1;
      default: w_next = IDLE;
    endcase
    if (!w_in_s[15]) w_next = IDLE;
  end
  // output is registered from the next state so the code appears the same edge SERVE is entered
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_req_d <= '0;
      r_pending <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      r_uo <= 8'hF0;
    end else begin
      r_state <= w_next;
      r_req_d <= w_in_s[14:0];
      r_pending <= w_pending;
      r_idx <= w_idx;
      r_cnt <= w_cnt;
      r_uo <= (w_next == SERVE) ? {4'h0, w_idx} : 8'hF0;
    end
endmodule

// File: tb/tb_tt_um_lab2_req_capture.sv
// tb_tt_um_lab2_req_capture: table-driven and scoreboarded checks of the request-capture stage
module tb_tt_um_lab2_req_capture;
  localparam int H = 4;
`ifdef LAB2_REQ_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 2;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic [7:0] ui_in = 8'h80;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  typedef struct {
    logic [14:0] req;
    logic [7:0] c1;
    logic [7:0] c2;
  } vec_t;
  vec_t v[6];
  always #5 clk = ~clk;
  tt_um_lab2_req_capture #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask
  task automatic drive(input logic en, input logic [14:0] req);
    ui_in = {en, req[14:8]};
    uio_in = req[7:0];
  endtask
  task automatic step(input string name);
    logic [7:0] e;
    @(posedge clk);
    #1;
    e = (q.size() > 0) ? q.pop_front() : 8'hF0;
    check(name, uo_out, e);
  endtask
  task automatic push_trace(input logic [7:0] c1, input logic [7:0] c2, input int n);
    logic [7:0] e;
    for (int j = 0; j < n; j++) begin
      e = 8'hF0;
      if (j >= L && j < L + H) e = c1;
      else if (c2 != 8'hF0 && j >= L + H + 2 && j < L + 2 * H + 2) e = c2;
      q.push_back(e);
    end
  endtask
  task automatic settle(input string name);
    drive(1'b1, 15'd0);
    repeat (3) q.push_back(8'hF0);
    while (q.size() > 0) step(name);
  endtask
  initial begin
    v[0] = '{15'h0008, 8'h03, 8'hF0};
    v[1] = '{15'h0204, 8'h09, 8'h02};
    v[2] = '{15'h0001, 8'h00, 8'hF0};
    v[3] = '{15'h4000, 8'h0E, 8'hF0};
    v[4] = '{15'h6000, 8'h0E, 8'h0D};
    v[5] = '{15'h0081, 8'h07, 8'h00};
    drive(1'b1, 15'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("in_reset", uo_out, 8'hF0);
    end
    check("uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'h00);
    rst_n = 1'b1;
    repeat (L + 6) q.push_back(8'hF0);
    while (q.size() > 0) step("post_reset");
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, v[i].req);
      push_trace(v[i].c1, v[i].c2, L + 2 * H + 4);
      while (q.size() > 0) step($sformatf("vec%0d", i));
      settle($sformatf("vec%0d_idle", i));
    end
    drive(1'b1, 15'h0002);
    push_trace(8'h01, 8'h0E, L + 2 * H + 4);
    for (int j = 0; q.size() > 0; j++) begin
      step("no_preempt");
      if (j == L) drive(1'b1, 15'h4002);
    end
    settle("no_preempt_idle");
    drive(1'b1, 15'h0020);
    for (int j = 0; j < 40; j++) q.push_back((j >= L && j < 2 * L) ? 8'h05 : 8'hF0);
    for (int j = 0; q.size() > 0; j++) begin
      step("enable_drop");
      if (j == L - 1) drive(1'b1, 15'h00A0);
      if (j == L) drive(1'b0, 15'h00A0);
      if (j == 15) drive(1'b1, 15'h00A0);
    end
    settle("enable_drop_idle");
    drive(1'b1, 15'h0040);
    push_trace(8'h06, 8'hF0, L + 2);
    while (q.size() > 0) step("pre_reset_serve");
    rst_n = 1'b0;
    #1;
    check("async_reset", uo_out, 8'hF0);
    drive(1'b1, 15'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) q.push_back(8'hF0);
    while (q.size() > 0) step("after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
